// File: rtl/graphics_sequencer.sv
// Per-frame graphics sequencer: optional fill, wrapped multi-line text, then the plot logic.
// Optional cursor glyph after the text when GRAPHICS_SEQUENCER_CURSOR_EN is defined.
module graphics_sequencer #(
    parameter int SYMBOL_WIDTH      = 7,
    parameter int HOR_ACTIVE_PIXELS = 640,
    parameter int VER_ACTIVE_PIXELS = 480,
    parameter int GLYPH_ADVANCE     = 15,
    parameter int LINE_HEIGHT       = 20,
    parameter int TEXT_ORIGIN_X     = 0,
    parameter int TEXT_ORIGIN_Y     = 440,
    parameter int MAX_LINES         = 2,
`ifdef GRAPHICS_SEQUENCER_CURSOR_EN
    parameter int CURSOR_GLYPH      = 95,
`endif
    parameter int NEWLINE_CODE      = 10,
    localparam int X_WIDTH          = $clog2(HOR_ACTIVE_PIXELS),
    localparam int Y_WIDTH          = $clog2(VER_ACTIVE_PIXELS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    swap,
    input  logic                    fill_en,
    output logic                    visible_iter_start,
    output logic                    iter_en,
    input  logic [SYMBOL_WIDTH-1:0] symbol,
    input  logic                    symbol_valid,
    output logic                    logic_start,
    input  logic                    logic_ready,
    input  logic                    logic_symbol_iter_en,
    output logic                    fill_drawer_start,
    input  logic                    fill_drawer_ready,
    output logic                    symbol_drawer_start,
    input  logic                    symbol_drawer_ready,
    output logic [X_WIDTH-1:0]      symbol_drawer_x,
    output logic [Y_WIDTH-1:0]      symbol_drawer_y,
    output logic [SYMBOL_WIDTH-1:0] symbol_drawer_glyph,
    output logic                    busy,
    output logic                    text_overflow
);
    localparam int LW = $clog2(MAX_LINES + 1);
    localparam logic [LW-1:0]           LAST_LINE = LW'(MAX_LINES);
    localparam logic [X_WIDTH:0]        X_ADV     = (X_WIDTH+1)'(GLYPH_ADVANCE);
    localparam logic [X_WIDTH:0]        X_WRAP    = (X_WIDTH+1)'(HOR_ACTIVE_PIXELS - GLYPH_ADVANCE);
    localparam logic [X_WIDTH-1:0]      X_ORG     = X_WIDTH'(TEXT_ORIGIN_X);
    localparam logic [Y_WIDTH-1:0]      Y_ORG     = Y_WIDTH'(TEXT_ORIGIN_Y);
    localparam logic [Y_WIDTH-1:0]      Y_STEP    = Y_WIDTH'(LINE_HEIGHT);
    localparam logic [SYMBOL_WIDTH-1:0] NL_CODE   = SYMBOL_WIDTH'(NEWLINE_CODE);
`ifdef GRAPHICS_SEQUENCER_CURSOR_EN
    localparam logic [SYMBOL_WIDTH-1:0] CUR_CODE  = SYMBOL_WIDTH'(CURSOR_GLYPH);
`endif

    typedef enum logic [3:0] {
        IDLE, FILL_START, FILL_W1, FILL_W2, ITER_START, ITER_NEXT,
        DRAW_START, DRAW_W1, DRAW_W2, LOGIC_START, LOGIC_W1, LOGIC_W2
`ifdef GRAPHICS_SEQUENCER_CURSOR_EN
        , CUR_START, CUR_W1, CUR_W2
`endif
    } state_t;

    state_t                  state, state_next;
    logic [X_WIDTH-1:0]      x;
    logic [Y_WIDTH-1:0]      y;
    logic [SYMBOL_WIDTH-1:0] glyph;
    logic [LW-1:0]           line;
    logic [X_WIDTH:0]        x_adv;
    logic                    lines_full;

    assign x_adv               = {1'b0, x} + X_ADV;
    assign lines_full          = (line >= LAST_LINE);
    assign busy                = (state != IDLE);
    assign symbol_drawer_x     = x;
    assign symbol_drawer_y     = y;
    assign symbol_drawer_glyph = glyph;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            x             <= X_ORG;
            y             <= Y_ORG;
            glyph         <= '0;
            line          <= '0;
            text_overflow <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (swap) begin
                    text_overflow <= 1'b0;
                    line          <= '0;
                    x             <= X_ORG;
                    y             <= Y_ORG;
                end
                ITER_START, ITER_NEXT: if (symbol_valid) begin
                    if (symbol == '0) begin
`ifdef GRAPHICS_SEQUENCER_CURSOR_EN
                        glyph <= CUR_CODE;
`endif
                    end else if (symbol == NL_CODE) begin
                        x <= X_ORG;
                        if (!lines_full) begin
                            line <= line + 1'b1;
                            y    <= y + Y_STEP;
                        end
                    end else if (lines_full) begin
                        text_overflow <= 1'b1;
                    end else begin
                        glyph <= symbol;
                    end
                end
                // Pen advances only once the drawer has accepted the glyph, so x/y hold during the draw.
                DRAW_W2: if (symbol_drawer_ready) begin
                    if (x_adv > X_WRAP) begin
                        x <= X_ORG;
                        if (!lines_full) begin
                            line <= line + 1'b1;
                            y    <= y + Y_STEP;
                        end
                    end else begin
                        x <= x_adv[X_WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next          = state;
        visible_iter_start  = 1'b0;
        iter_en             = logic_symbol_iter_en;
        logic_start         = 1'b0;
        fill_drawer_start   = 1'b0;
        symbol_drawer_start = 1'b0;
        case (state)
            IDLE:        if (swap) state_next = fill_en ? FILL_START : ITER_START;
            FILL_START: begin
                fill_drawer_start = 1'b1;
                state_next        = FILL_W1;
            end
            FILL_W1:     state_next = FILL_W2;
            FILL_W2:     if (fill_drawer_ready) state_next = ITER_START;
            ITER_START, ITER_NEXT: begin
                visible_iter_start = (state == ITER_START);
                iter_en            = logic_symbol_iter_en | ~symbol_valid;
                state_next         = ITER_NEXT;
                if (symbol_valid) begin
                    if (symbol == '0) begin
`ifdef GRAPHICS_SEQUENCER_CURSOR_EN
                        state_next = lines_full ? LOGIC_START : CUR_START;
`else
                        state_next = LOGIC_START;
`endif
                    end else if (symbol != NL_CODE && !lines_full) begin
                        state_next = DRAW_START;
                    end
                end
            end
            DRAW_START: begin
                symbol_drawer_start = 1'b1;
                state_next          = DRAW_W1;
            end
            DRAW_W1:     state_next = DRAW_W2;
            DRAW_W2:     if (symbol_drawer_ready) state_next = ITER_NEXT;
`ifdef GRAPHICS_SEQUENCER_CURSOR_EN
            CUR_START: begin
                symbol_drawer_start = 1'b1;
                state_next          = CUR_W1;
            end
            CUR_W1:      state_next = CUR_W2;
            CUR_W2:      if (symbol_drawer_ready) state_next = LOGIC_START;
`endif
            LOGIC_START: begin
                logic_start = 1'b1;
                state_next  = LOGIC_W1;
            end
            LOGIC_W1:    state_next = LOGIC_W2;
            LOGIC_W2:    if (logic_ready) state_next = IDLE;
            default:     state_next = IDLE;
        endcase
    end
endmodule
